load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_lane_align.sv | 57 +++++
 rtl/load_store_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - ReqSize encodings (byte, half, word, illegal)
//   - FSM state enumeration
//   - is_misaligned(): alignment / legal-size check applied at accept
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_STORE     = 3'd2,
    ST_RMW_READ  = 3'd3,
    ST_RMW_WRITE = 3'd4,
    ST_RESP      = 3'd5,
    ST_ERR       = 3'd6
  } lsu_state_t;

  // A request is rejected when its size is illegal or the address is not a
  // multiple of the access size.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (size)
      SIZE_BYTE:    bad = 1'b0;
      SIZE_HALF:    bad = addr_lo[0];
      SIZE_WORD:    bad = |addr_lo;
      SIZE_ILLEGAL: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane logic for the load/store unit.
// Little-endian lanes: byte k of a word is bits [8k+7:8k].
// Ports:
//   word        in  32  word read from data memory
//   addr_lo     in  2   low address bits of the access
//   size        in  2   access size (lsu_pkg SIZE_*)
//   sign_ext    in  1   sign-extend loads when 1
//   wdata       in  32  right-justified store data
//   load_data   out 32  selected lane(s), sign/zero extended
//   merged_word out 32  word with the target lane(s) replaced by wdata
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  byte_shift;
  logic [4:0]  half_shift;
  logic [31:0] shifted;
  logic [31:0] lane_mask;
  logic [31:0] placed;

  always_comb begin
    byte_shift = {addr_lo, 3'b000};
    half_shift = {addr_lo[1], 4'b0000};
    shifted    = word >> byte_shift;

    load_data   = word;
    lane_mask   = 32'hFFFF_FFFF;
    placed      = wdata;
    case (size)
      SIZE_BYTE: begin
        load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
        lane_mask = 32'h0000_00FF << byte_shift;
        placed    = wdata << byte_shift;
      end
      SIZE_HALF: begin
        load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        lane_mask = 32'h0000_FFFF << half_shift;
        placed    = wdata << half_shift;
      end
      default: begin
        load_data = word;
        lane_mask = 32'hFFFF_FFFF;
        placed    = wdata;
      end
    endcase
    merged_word = (word & ~lane_mask) | (placed & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store unit in front of a
// combinational-read, edge-write data memory.
// Handshake: a request is taken on any rising CLK edge where the unit is
// idle (Busy=0) and ReqValid=1; while Busy=1 ReqValid is ignored (nothing
// is queued). Completion is a one-cycle RespValid pulse carrying RespRData
// and AddrError.
// Ports:
//   CLK, RESET (sync, active-high)
//   ReqValid/ReqWrite/ReqSize/ReqSigned/ReqAddr/ReqWData  request
//   Busy, RespValid, RespRData, AddrError                  response
//   MemRead, MemWrite, MemAddress, MemWriteData, MemReadData  memory port
//   DbgState  current FSM state
// Sub-word stores are read-modify-write: read the word, merge, write back.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ReqValid,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        Busy,
  output logic        RespValid,
  output logic [31:0] RespRData,
  output logic        AddrError,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  input  logic [31:0] MemReadData,
  output lsu_state_t  DbgState
);

  lsu_state_t  state;
  logic [1:0]  cap_size;
  logic        cap_sign;
  logic [1:0]  cap_addr_lo;
  logic [31:0] cap_wdata;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign DbgState = state;

  lsu_lane_align u_lane_align (
    .word        (MemReadData),
    .addr_lo     (cap_addr_lo),
    .size        (cap_size),
    .sign_ext    (cap_sign),
    .wdata       (cap_wdata),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // All outputs are registered and set on the transition into the state
  // that owns them, so each is a clean function of the current state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= ST_IDLE;
      Busy         <= 1'b0;
      RespValid    <= 1'b0;
      AddrError    <= 1'b0;
      RespRData    <= 32'd0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      MemAddress   <= 32'd0;
      MemWriteData <= 32'd0;
      cap_size     <= SIZE_BYTE;
      cap_sign     <= 1'b0;
      cap_addr_lo  <= 2'b00;
      cap_wdata    <= 32'd0;
    end else begin
      RespValid    <= 1'b0;
      AddrError    <= 1'b0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
      MemWriteData <= 32'd0;
      case (state)
        ST_IDLE: begin
          if (ReqValid) begin
            cap_size    <= ReqSize;
            cap_sign    <= ReqSigned;
            cap_addr_lo <= ReqAddr[1:0];
            cap_wdata   <= ReqWData;
            MemAddress  <= {ReqAddr[31:2], 2'b00};
            RespRData   <= 32'd0;
            Busy        <= 1'b1;
            if (is_misaligned(ReqSize, ReqAddr[1:0])) begin
              state     <= ST_ERR;
              RespValid <= 1'b1;
              AddrError <= 1'b1;
            end else if (!ReqWrite) begin
              state   <= ST_LOAD;
              MemRead <= 1'b1;
            end else if (ReqSize == SIZE_WORD) begin
              state        <= ST_STORE;
              MemWrite     <= 1'b1;
              MemWriteData <= ReqWData;
            end else begin
              state   <= ST_RMW_READ;
              MemRead <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          RespRData <= load_data;
          RespValid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_STORE: begin
          RespValid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RMW_READ: begin
          MemWrite     <= 1'b1;
          MemWriteData <= merged_word;
          state        <= ST_RMW_WRITE;
        end
        ST_RMW_WRITE: begin
          RespValid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP, ST_ERR: begin
          RespRData <= 32'd0;
          Busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
